// File: rtl/renode_axi_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite-style manager port between NUM_REQ requesters.
// One transaction in flight at a time; the winner gets a single-cycle response pulse.
module renode_axi_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ-1:0]               req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             err_o,
    output logic                             busy_o,
    output logic [ADDR_WIDTH-1:0]            awaddr_o,
    output logic                             awvalid_o,
    input  logic                             awready_i,
    output logic [DATA_WIDTH-1:0]            wdata_o,
    output logic [STRB_WIDTH-1:0]            wstrb_o,
    output logic                             wvalid_o,
    input  logic                             wready_i,
    input  logic [1:0]                       bresp_i,
    input  logic                             bvalid_i,
    output logic                             bready_o,
    output logic [ADDR_WIDTH-1:0]            araddr_o,
    output logic                             arvalid_o,
    input  logic                             arready_i,
    input  logic [DATA_WIDTH-1:0]            rdata_i,
    input  logic [1:0]                       rresp_i,
    input  logic                             rvalid_i,
    output logic                             rready_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CW    = IDX_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [IDX_W-1:0]      r_last;
    logic [IDX_W-1:0]      r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [STRB_WIDTH-1:0] r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_aw_done;
    logic                  r_w_done;

    logic                  w_found;
    logic [IDX_W-1:0]      w_win;
    logic [CW-1:0]         w_cand;
    logic                  w_grant;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [NUM_REQ-1:0]    w_rvalid;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [STRB_WIDTH-1:0] w_sel_be;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_unused_resp;

    // Only bit 1 of the AXI response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign w_unused_resp = bresp_i[0] ^ rresp_i[0];

    // Round-robin scan starting just after the last winner, with wrap-around.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = CW'(r_last) + CW'(1) + CW'(k);
            if (w_cand >= CW'(NUM_REQ)) begin
                w_cand = w_cand - CW'(NUM_REQ);
            end
            if (!w_found && req_i[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IDX_W-1:0];
            end
        end
    end

    // Payload mux for the current winner.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == w_win) begin
                w_sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_be    = req_be_i[i*STRB_WIDTH +: STRB_WIDTH];
                w_sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign awvalid_o = (r_state == S_WR) && !r_aw_done;
    assign wvalid_o  = (r_state == S_WR) && !r_w_done;
    assign bready_o  = (r_state == S_WR_RESP);
    assign arvalid_o = (r_state == S_RD_ADDR);
    assign rready_o  = (r_state == S_RD_DATA);
    assign busy_o    = (r_state != S_IDLE);
    assign w_aw_hs   = awvalid_o && awready_i;
    assign w_w_hs    = wvalid_o && wready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_gnt       = '0;
        w_rvalid    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && rst_ni) begin
                    w_grant      = 1'b1;
                    w_gnt[w_win] = 1'b1;
                    w_state_nxt  = req_we_i[w_win] ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid_i) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RD_ADDR: begin
                if (arready_i) begin
                    w_state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid_i) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_rvalid[r_idx] = 1'b1;
                w_state_nxt     = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = w_rvalid;

    // Transaction payload, handshake progress and response capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_idx     <= '0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last    <= w_win;
                r_idx     <= w_win;
                r_addr    <= w_sel_addr;
                r_be      <= w_sel_be;
                r_wdata   <= w_sel_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if ((r_state == S_WR_RESP) && bvalid_i) begin
                r_err   <= bresp_i[1];
                r_rdata <= '0;
            end
            if ((r_state == S_RD_DATA) && rvalid_i) begin
                r_err   <= rresp_i[1];
                r_rdata <= rdata_i;
            end
        end
    end

    assign awaddr_o = r_addr;
    assign araddr_o = r_addr;
    assign wdata_o  = r_wdata;
    assign wstrb_o  = r_be;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

endmodule

// File: tb/tb_renode_axi_arbiter.sv
// Directed bench for renode_axi_arbiter (2 requesters); the bench itself plays the AXI memory side.
module tb_renode_axi_arbiter;

    logic         clk;
    logic         rst_ni;
    logic [1:0]   req_i;
    logic [1:0]   req_we_i;
    logic [63:0]  req_addr_i;
    logic [15:0]  req_be_i;
    logic [127:0] req_wdata_i;
    logic [1:0]   gnt_o;
    logic [1:0]   rvalid_o;
    logic [63:0]  rdata_o;
    logic         err_o;
    logic         busy_o;
    logic [31:0]  awaddr_o;
    logic         awvalid_o;
    logic         awready_i;
    logic [63:0]  wdata_o;
    logic [7:0]   wstrb_o;
    logic         wvalid_o;
    logic         wready_i;
    logic [1:0]   bresp_i;
    logic         bvalid_i;
    logic         bready_o;
    logic [31:0]  araddr_o;
    logic         arvalid_o;
    logic         arready_i;
    logic [63:0]  rdata_i;
    logic [1:0]   rresp_i;
    logic         rvalid_i;
    logic         rready_o;

    int n_checks = 0;
    int n_errors = 0;

    renode_axi_arbiter #(
        .NUM_REQ    (2),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_be_i    (req_be_i),
        .req_wdata_i (req_wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .awaddr_o    (awaddr_o),
        .awvalid_o   (awvalid_o),
        .awready_i   (awready_i),
        .wdata_o     (wdata_o),
        .wstrb_o     (wstrb_o),
        .wvalid_o    (wvalid_o),
        .wready_i    (wready_i),
        .bresp_i     (bresp_i),
        .bvalid_i    (bvalid_i),
        .bready_o    (bready_o),
        .araddr_o    (araddr_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .rdata_i     (rdata_i),
        .rresp_i     (rresp_i),
        .rvalid_i    (rvalid_i),
        .rready_o    (rready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Single comparison with failure report.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called in IDLE with the request already applied: checks grant, waits for the response.
    task automatic run_txn(input logic [1:0] eg, input logic [63:0] erd, input logic ee,
                           input int elat, input logic drop);
        int  n;
        logic got;
        n   = 0;
        got = 1'b0;
        chk("gnt", 64'(gnt_o), 64'(eg));
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            n++;
            if (rvalid_o != 2'b00) got = 1'b1;
            else chk("no_extra_gnt", 64'(gnt_o), 64'(2'b00));
        end
        chk("resp_seen", 64'(got), 64'(1'b1));
        chk("latency", 64'(n), 64'(elat));
        chk("rvalid", 64'(rvalid_o), 64'(eg));
        chk("rdata", rdata_o, erd);
        chk("err", 64'(err_o), 64'(ee));
        if (drop) req_i = 2'b00;
        tick();
        chk("idle_busy", 64'(busy_o), 64'(1'b0));
        chk("idle_rvalid", 64'(rvalid_o), 64'(2'b00));
    endtask

    initial begin
        rst_ni = 1'b0;
        req_i = '0; req_we_i = '0; req_addr_i = '0; req_be_i = '0; req_wdata_i = '0;
        awready_i = 1'b0; wready_i = 1'b0; bresp_i = '0; bvalid_i = 1'b0;
        arready_i = 1'b0; rdata_i = '0; rresp_i = '0; rvalid_i = 1'b0;
        #3;
        chk("rst_gnt", 64'(gnt_o), 64'(2'b00));
        chk("rst_rvalid", 64'(rvalid_o), 64'(2'b00));
        chk("rst_busy", 64'(busy_o), 64'(1'b0));
        chk("rst_rdata", rdata_o, 64'h0);
        chk("rst_err", 64'(err_o), 64'(1'b0));
        chk("rst_awvalid", 64'(awvalid_o), 64'(1'b0));
        chk("rst_arvalid", 64'(arvalid_o), 64'(1'b0));
        tick();
        rst_ni = 1'b1;

        // Simultaneous reads from both requesters, held high for four transactions.
        req_we_i = 2'b00;
        req_addr_i = {32'h0000_3000, 32'h0000_2000};
        arready_i = 1'b1; rvalid_i = 1'b1; rdata_i = 64'h5A; rresp_i = 2'b00;
        req_i = 2'b11;
        #1;
        run_txn(2'b01, 64'h5A, 1'b0, 3, 1'b0);
        run_txn(2'b10, 64'h5A, 1'b0, 3, 1'b0);
        run_txn(2'b01, 64'h5A, 1'b0, 3, 1'b0);
        run_txn(2'b10, 64'h5A, 1'b0, 3, 1'b1);

        // Single write from requester 0.
        awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b1; bresp_i = 2'b00;
        req_we_i = 2'b01;
        req_addr_i = {32'h0, 32'h0000_10C0};
        req_be_i = {8'h00, 8'hFF};
        req_wdata_i = {64'h0, 64'h100};
        req_i = 2'b01;
        #1;
        chk("wr_gnt", 64'(gnt_o), 64'(2'b01));
        tick();
        req_i = 2'b00;
        #1;
        chk("wr_awvalid", 64'(awvalid_o), 64'(1'b1));
        chk("wr_wvalid", 64'(wvalid_o), 64'(1'b1));
        chk("wr_awaddr", 64'(awaddr_o), 64'(32'h10C0));
        chk("wr_wdata", wdata_o, 64'h100);
        chk("wr_wstrb", 64'(wstrb_o), 64'(8'hFF));
        chk("wr_busy", 64'(busy_o), 64'(1'b1));
        tick();
        chk("wr_bready", 64'(bready_o), 64'(1'b1));
        chk("wr_awvalid_low", 64'(awvalid_o), 64'(1'b0));
        tick();
        chk("wr_rvalid", 64'(rvalid_o), 64'(2'b01));
        chk("wr_err", 64'(err_o), 64'(1'b0));
        chk("wr_rdata_zero", rdata_o, 64'h0);
        tick();
        chk("wr_idle", 64'(busy_o), 64'(1'b0));

        // Read back from requester 0.
        req_we_i = 2'b00;
        rdata_i = 64'h100;
        req_i = 2'b01;
        #1;
        run_txn(2'b01, 64'h100, 1'b0, 3, 1'b1);

        // Split write handshake: AW accepted at cycle+1, W at cycle+4.
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
        req_we_i = 2'b01;
        req_addr_i = {32'h0, 32'h0000_0040};
        req_be_i = {8'h00, 8'h0F};
        req_wdata_i = {64'h0, 64'h1234};
        req_i = 2'b01;
        #1;
        chk("sp_gnt", 64'(gnt_o), 64'(2'b01));
        tick();
        req_i = 2'b00;
        awready_i = 1'b1;
        #1;
        chk("sp_c1_awvalid", 64'(awvalid_o), 64'(1'b1));
        chk("sp_c1_wvalid", 64'(wvalid_o), 64'(1'b1));
        chk("sp_c1_bready", 64'(bready_o), 64'(1'b0));
        tick();
        awready_i = 1'b0;
        #1;
        chk("sp_c2_awvalid", 64'(awvalid_o), 64'(1'b0));
        chk("sp_c2_wvalid", 64'(wvalid_o), 64'(1'b1));
        chk("sp_c2_bready", 64'(bready_o), 64'(1'b0));
        tick();
        chk("sp_c3_wvalid", 64'(wvalid_o), 64'(1'b1));
        chk("sp_c3_wstrb", 64'(wstrb_o), 64'(8'h0F));
        chk("sp_c3_bready", 64'(bready_o), 64'(1'b0));
        tick();
        wready_i = 1'b1;
        #1;
        chk("sp_c4_wvalid", 64'(wvalid_o), 64'(1'b1));
        chk("sp_c4_bready", 64'(bready_o), 64'(1'b0));
        tick();
        wready_i = 1'b0;
        #1;
        chk("sp_c5_wvalid", 64'(wvalid_o), 64'(1'b0));
        chk("sp_c5_bready", 64'(bready_o), 64'(1'b1));
        bvalid_i = 1'b1; bresp_i = 2'b00;
        tick();
        chk("sp_rvalid", 64'(rvalid_o), 64'(2'b01));
        chk("sp_err", 64'(err_o), 64'(1'b0));
        bvalid_i = 1'b0;
        tick();
        chk("sp_idle", 64'(busy_o), 64'(1'b0));

        // Error responses: SLVERR on a read, DECERR on a write from requester 1.
        awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b1; bresp_i = 2'b11;
        arready_i = 1'b1; rvalid_i = 1'b1; rdata_i = 64'hDEAD; rresp_i = 2'b10;
        req_we_i = 2'b00;
        req_addr_i = {32'h0, 32'h0000_1018};
        req_i = 2'b01;
        #1;
        run_txn(2'b01, 64'hDEAD, 1'b1, 3, 1'b1);
        req_we_i = 2'b10;
        req_addr_i = {32'h0000_2000, 32'h0};
        req_i = 2'b10;
        #1;
        run_txn(2'b10, 64'h0, 1'b1, 3, 1'b1);

        // Backpressure on AR and R with requester 1 waiting throughout.
        arready_i = 1'b0; rvalid_i = 1'b0;
        req_we_i = 2'b00;
        req_addr_i = {32'h0000_4444, 32'h0000_3000};
        req_i = 2'b11;
        #1;
        chk("bp_gnt", 64'(gnt_o), 64'(2'b01));
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("bp_arvalid", 64'(arvalid_o), 64'(1'b1));
            chk("bp_araddr", 64'(araddr_o), 64'(32'h3000));
            chk("bp_ar_gnt", 64'(gnt_o), 64'(2'b00));
            chk("bp_ar_busy", 64'(busy_o), 64'(1'b1));
            tick();
        end
        arready_i = 1'b1;
        #1;
        chk("bp_arvalid_hs", 64'(arvalid_o), 64'(1'b1));
        tick();
        arready_i = 1'b0;
        #1;
        chk("bp_arvalid_low", 64'(arvalid_o), 64'(1'b0));
        for (int c = 0; c < 5; c++) begin
            chk("bp_rready", 64'(rready_o), 64'(1'b1));
            chk("bp_r_gnt", 64'(gnt_o), 64'(2'b00));
            chk("bp_r_busy", 64'(busy_o), 64'(1'b1));
            tick();
        end
        rvalid_i = 1'b1; rdata_i = 64'h77; rresp_i = 2'b01;
        tick();
        chk("bp_rvalid", 64'(rvalid_o), 64'(2'b01));
        chk("bp_rdata", rdata_o, 64'h77);
        chk("bp_err_exokay", 64'(err_o), 64'(1'b0));
        req_i = 2'b00;
        rvalid_i = 1'b0;
        tick();
        chk("bp_idle", 64'(busy_o), 64'(1'b0));

        // Reset while in RD_DATA.
        arready_i = 1'b1; rvalid_i = 1'b0;
        req_addr_i = {32'h0, 32'h0000_5000};
        req_i = 2'b01;
        #1;
        chk("rr_gnt", 64'(gnt_o), 64'(2'b01));
        tick();
        tick();
        chk("rr_rready", 64'(rready_o), 64'(1'b1));
        req_i = 2'b11;
        rst_ni = 1'b0;
        #1;
        chk("rr_rready0", 64'(rready_o), 64'(1'b0));
        chk("rr_arvalid0", 64'(arvalid_o), 64'(1'b0));
        chk("rr_busy0", 64'(busy_o), 64'(1'b0));
        chk("rr_gnt0", 64'(gnt_o), 64'(2'b00));
        chk("rr_rdata0", rdata_o, 64'h0);
        chk("rr_rvalid0", 64'(rvalid_o), 64'(2'b00));
        chk("rr_awvalid0", 64'(awvalid_o), 64'(1'b0));
        chk("rr_wvalid0", 64'(wvalid_o), 64'(1'b0));
        tick();
        chk("rr_hold_busy", 64'(busy_o), 64'(1'b0));
        chk("rr_hold_rvalid", 64'(rvalid_o), 64'(2'b00));
        rvalid_i = 1'b1; rdata_i = 64'h99; rresp_i = 2'b00;
        rst_ni = 1'b1;
        #1;
        run_txn(2'b01, 64'h99, 1'b0, 3, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
